// File: rtl/step_sequencer_if.sv
// Engine-side bus of the step sequencer.
// Handshake: eng_start is a one-cycle issue pulse that qualifies eng_sel and
// eng_data. eng_done is a one-cycle completion pulse that qualifies
// eng_result. There is no backpressure. The engine accepts every issue, and at
// most one step is outstanding at a time.
interface step_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 2
);
  logic              eng_start;
  logic [OP_W-1:0]   eng_sel;
  logic [DATA_W-1:0] eng_data;
  logic              eng_done;
  logic [DATA_W-1:0] eng_result;

  modport master (output eng_start, eng_sel, eng_data, input eng_done, eng_result);
  modport slave  (input eng_start, eng_sel, eng_data, output eng_done, eng_result);
endinterface

// File: rtl/step_sequencer.sv
// Programmable step sequencer. It runs an accumulator through up to MAX_STEPS
// engine operations and supports abort, a per-step timeout and a variable
// step count.
module step_sequencer #(
  parameter int DATA_W    = 8,
  parameter int MAX_STEPS = 8,
  parameter int OP_W      = 2,
  parameter int TIMEOUT   = 255,
  localparam int IDX_W    = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1,
  localparam int CNT_W    = $clog2(MAX_STEPS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DATA_W-1:0]         data_in,
  input  logic [CNT_W-1:0]          num_steps,
  input  logic [MAX_STEPS*OP_W-1:0] step_ops,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [DATA_W-1:0]         data_out,
  output logic [IDX_W-1:0]          step_idx,
  output logic [1:0]                state_dbg,
  step_sequencer_if.master          eng
);

  // The counter only has to reach TIMEOUT-1.
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t                    state;
  logic [DATA_W-1:0]         acc;
  logic [MAX_STEPS*OP_W-1:0] ops_r;
  logic [CNT_W-1:0]          n_r;
  logic [TMO_W-1:0]          wait_cnt;
  logic                      timed_out;
  logic                      start_r;
  logic                      last_step;
  logic                      timeout_hit;

  // Outputs derived directly from registers.
  assign busy          = (state != IDLE);
  assign state_dbg     = state;
  assign eng.eng_start = start_r;
  assign eng.eng_sel   = ops_r[step_idx*OP_W +: OP_W];
  assign eng.eng_data  = acc;

  // Step bookkeeping: last-step detect and the timeout limit for the current wait.
  assign last_step   = ((CNT_W'(step_idx) + CNT_W'(1)) == n_r);
  assign timeout_hit = (TIMEOUT != 0) && (int'(wait_cnt) == TIMEOUT - 1);

  // Sequencer FSM with registered done/error/eng_start pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      ops_r     <= '0;
      n_r       <= '0;
      wait_cnt  <= '0;
      timed_out <= 1'b0;
      start_r   <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      data_out  <= '0;
      step_idx  <= '0;
    end else begin
      done    <= 1'b0;
      error   <= 1'b0;
      start_r <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc       <= data_in;
            ops_r     <= step_ops;
            n_r       <= (num_steps > CNT_W'(MAX_STEPS)) ? CNT_W'(MAX_STEPS) : num_steps;
            step_idx  <= '0;
            timed_out <= 1'b0;
            if (num_steps == '0) begin
              state <= FINISH;
            end else begin
              state   <= ISSUE;
              start_r <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            state    <= WAIT;
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          // Abort outranks a completing engine and an expiring timeout.
          if (abort) begin
            state <= IDLE;
          end else if (eng.eng_done) begin
            acc <= eng.eng_result;
            if (last_step) begin
              state <= FINISH;
            end else begin
              step_idx <= step_idx + IDX_W'(1);
              state    <= ISSUE;
              start_r  <= 1'b1;
            end
          end else if (timeout_hit) begin
            timed_out <= 1'b1;
            state     <= FINISH;
          end else begin
            wait_cnt <= wait_cnt + TMO_W'(1);
          end
        end
        FINISH: begin
          state <= IDLE;
          // A timed-out run reports an error and keeps the previous result.
          if (!abort) begin
            done <= 1'b1;
            if (timed_out) begin
              error <= 1'b1;
            end else begin
              data_out <= acc;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer. It has a two-cycle engine model, directed runs, and a
// scoreboard for done/data_out/error and engine issues.
module tb_step_sequencer;

  localparam int DATA_W = 8;
  localparam int MAXS   = 8;
  localparam int OP_W   = 2;
  localparam int CNT_W  = 4;
  localparam int IDX_W  = 3;
  localparam int ENG_L  = 2;
  localparam int DW     = 25;   // {cycle[15:0], error, data_out[7:0]}
  localparam int EW     = 10;   // {sel[1:0], data[7:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                   start = 1'b0;
  logic [DATA_W-1:0]      data_in = '0;
  logic [CNT_W-1:0]       num_steps = '0;
  logic [MAXS*OP_W-1:0]   step_ops = '0;
  logic                   abort = 1'b0;
  logic                   busy, done, error;
  logic [DATA_W-1:0]      data_out;
  logic [IDX_W-1:0]       step_idx;
  logic [1:0]             state_dbg;

  step_sequencer_if #(.DATA_W(DATA_W), .OP_W(OP_W)) eng_bus ();

  step_sequencer #(.DATA_W(DATA_W), .MAX_STEPS(MAXS), .OP_W(OP_W), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
    .num_steps(num_steps), .step_ops(step_ops), .abort(abort),
    .busy(busy), .done(done), .error(error), .data_out(data_out),
    .step_idx(step_idx), .state_dbg(state_dbg), .eng(eng_bus)
  );

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  logic [EW-1:0] eng_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int eng_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- engine model ----------------
  logic       silent = 1'b0;
  int         stray_cnt = 0;
  int         stray_seen = 0;

  function automatic logic [DATA_W-1:0] eng_calc(input logic [1:0] sel, input logic [DATA_W-1:0] d);
    case (sel)
      2'd0:    return d + 8'd3;
      2'd1:    return d << 1;
      2'd2:    return ~d;
      default: return d >> 1;
    endcase
  endfunction

  initial begin
    logic              pend;
    int                cnt;
    logic [DATA_W-1:0] res;
    pend = 1'b0;
    cnt = 0;
    res = '0;
    eng_bus.eng_done = 1'b0;
    eng_bus.eng_result = '0;
    forever begin
      @(negedge clk);
      eng_bus.eng_done = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend = 1'b0;
          eng_bus.eng_done = 1'b1;
          eng_bus.eng_result = res;
        end
      end
      if (stray_cnt != stray_seen) begin
        stray_seen++;
        eng_bus.eng_done = 1'b1;
        eng_bus.eng_result = 8'h77;
      end
      if (eng_bus.eng_start && !silent) begin
        pend = 1'b1;
        cnt = ENG_L;
        res = eng_calc(eng_bus.eng_sel, eng_bus.eng_data);
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [DW-1:0] e;
    logic [EW-1:0] g;
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", {16'(cyc), error, data_out}, '0);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle_err_data", {7'd0, 16'(cyc), error, data_out}, {7'd0, e});
        end
      end
      if (error) check("error_with_done", 32'(done), 32'd1);
      if (eng_bus.eng_start) begin
        eng_cnt++;
        if (eng_q.size() == 0) begin
          check("unexpected_eng_start", {eng_bus.eng_sel, eng_bus.eng_data}, '1);
        end else begin
          g = eng_q.pop_front();
          check("eng_sel_data", 32'({eng_bus.eng_sel, eng_bus.eng_data}), 32'(g));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge. It returns at the negedge after the start-sampling edge.
  task automatic run_start(input logic [7:0] d, input logic [3:0] n, input logic [15:0] ops);
    data_in = d;
    num_steps = n;
    step_ops = ops;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_done(input int steps_cycles, input logic err, input logic [7:0] d);
    exp_q.push_back({16'(cyc + 1 + steps_cycles), err, d});
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_error"}, 32'(error), 0);
    check({tag, "_eng_start"}, 32'(eng_bus.eng_start), 0);
    check({tag, "_data_out"}, 32'(data_out), 0);
    check({tag, "_step_idx"}, 32'(step_idx), 0);
    check({tag, "_state"}, 32'(state_dbg), 0);
    check({tag, "_eng_sel_data"}, 32'({eng_bus.eng_sel, eng_bus.eng_data}), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: ops {0,1,1,2}, n=4, data 5 -> 5,8,16,32 issued, 0xDF at edge 13
    push_done(13, 1'b0, 8'hDF);
    eng_q.push_back({2'd0, 8'd5});
    eng_q.push_back({2'd1, 8'd8});
    eng_q.push_back({2'd1, 8'd16});
    eng_q.push_back({2'd2, 8'd32});
    c0 = eng_cnt;
    run_start(8'd5, 4'd4, 16'h0094);
    repeat (14) @(negedge clk);
    check("c1_eng_count", 32'(eng_cnt - c0), 4);
    check("c1_pending", 32'(exp_q.size()), 0);
    check("c1_busy_after", 32'(busy), 0);
    check("c1_data_out", 32'(data_out), 32'hDF);

    // 2: n=0 -> done at edge 1 with data_in, no engine issue
    push_done(1, 1'b0, 8'hA5);
    c0 = eng_cnt;
    run_start(8'hA5, 4'd0, 16'h0000);
    repeat (2) @(negedge clk);
    check("c2_eng_count", 32'(eng_cnt - c0), 0);
    check("c2_pending", 32'(exp_q.size()), 0);
    check("c2_data_out", 32'(data_out), 32'hA5);

    // 3: silent engine, TIMEOUT=4 -> done+error at edge 6, data_out kept
    silent = 1'b1;
    push_done(6, 1'b1, 8'hA5);
    eng_q.push_back({2'd0, 8'h10});
    run_start(8'h10, 4'd1, 16'h0000);
    repeat (7) @(negedge clk);
    silent = 1'b0;
    check("c3_pending", 32'(exp_q.size()), 0);
    check("c3_busy_after", 32'(busy), 0);
    check("c3_data_out_kept", 32'(data_out), 32'hA5);

    // 4: abort during the second step's WAIT, coinciding with eng_done
    eng_q.push_back({2'd0, 8'd5});
    eng_q.push_back({2'd1, 8'd8});
    run_start(8'd5, 4'd4, 16'h0094);
    repeat (5) @(negedge clk);
    check("c4_eng_done_with_abort", 32'(eng_bus.eng_done), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("c4_idle_after_abort", 32'(busy), 0);
    repeat (4) @(negedge clk);
    check("c4_data_out_kept", 32'(data_out), 32'hA5);
    check("c4_no_done", 32'(exp_q.size()), 0);
    push_done(4, 1'b0, 8'h02);
    eng_q.push_back({2'd0, 8'hFF});
    run_start(8'hFF, 4'd1, 16'h0000);
    repeat (5) @(negedge clk);
    check("c4_restart_data_out", 32'(data_out), 32'h02);

    // 5: stray eng_done in IDLE and ISSUE, start pulses while busy
    @(posedge clk);
    #1 stray_cnt++;
    repeat (2) @(negedge clk);
    check("c5_idle_stray_busy", 32'(busy), 0);
    check("c5_idle_stray_data", 32'(data_out), 32'h02);
    push_done(13, 1'b0, 8'hDF);
    eng_q.push_back({2'd0, 8'd5});
    eng_q.push_back({2'd1, 8'd8});
    eng_q.push_back({2'd1, 8'd16});
    eng_q.push_back({2'd2, 8'd32});
    c0 = eng_cnt;
    data_in = 8'd5;
    num_steps = 4'd4;
    step_ops = 16'h0094;
    start = 1'b1;
    @(posedge clk);
    #1 stray_cnt++;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    data_in = 8'h11;
    num_steps = 4'd1;
    step_ops = 16'h0003;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("c5_eng_count", 32'(eng_cnt - c0), 4);
    check("c5_pending", 32'(exp_q.size()), 0);
    check("c5_data_out", 32'(data_out), 32'hDF);

    // 6: reset in WAIT, late eng_done ignored, next run correct
    eng_q.push_back({2'd0, 8'd5});
    c0 = eng_cnt;
    run_start(8'd5, 4'd4, 16'h0094);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("c6_reset");
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("c6_eng_count", 32'(eng_cnt - c0), 1);
    check("c6_busy_after", 32'(busy), 0);
    check("c6_data_out", 32'(data_out), 0);
    push_done(4, 1'b0, 8'h10);
    eng_q.push_back({2'd3, 8'h20});
    run_start(8'h20, 4'd1, 16'h0003);
    repeat (5) @(negedge clk);
    check("c6_next_run_data", 32'(data_out), 32'h10);

    // final report
    check("final_done_queue", 32'(exp_q.size()), 0);
    check("final_eng_queue", 32'(eng_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
